// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period arithmetic,
// common to the receive and transmit sides.
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam int UART_DATA_BITS = 8;

    // Clock cycles per serial bit (integer division).
    function automatic int uart_div(input int fclk, input int bauds);
        return fclk / bauds;
    endfunction

    // Offset from the start-bit edge to the middle of the start bit.
    function automatic int uart_half(input int fclk, input int bauds);
        return uart_div(fclk, bauds) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, received byte and status pulses out.
interface uart_rx_if;

    logic       RXD;
    logic [7:0] DOUT;
    logic       VALID;
    logic       FERR;
    logic       BUSY;

    modport master (output RXD, input DOUT, VALID, FERR, BUSY);
    modport slave  (input RXD, output DOUT, VALID, FERR, BUSY);

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so reset never fakes a start bit.
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: single mid-bit sample per bit, one-cycle VALID/FERR
// pulses, and a BREAK state that holds off start detection while the line is low.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int Bauds = 300,
    parameter int Fclk  = 48_000_000
) (
    input  logic     CLK,
    input  logic     RST_,
    uart_rx_if.slave rx_if
);

    localparam int D  = uart_div(Fclk, Bauds);
    localparam int H  = uart_half(Fclk, Bauds);
    localparam int CW = $clog2(D) + 1;

    localparam logic [CW-1:0] HALF_LOAD = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(D - 1);

    if (D < 4) begin : g_cfg_check
        $error("uart_rx: Fclk/Bauds must be at least 4 clocks per bit");
    end

    logic          rxs;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    sync2 u_sync (
        .clk_i  (CLK),
        .rst_ni (RST_),
        .d_i    (rx_if.RXD),
        .q_o    (rxs)
    );

    // The counter is loaded so that it reaches zero exactly on each sample cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = BIT_LOAD;
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = BIT_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_if.DOUT  = dout_q;
    assign rx_if.VALID = valid_q;
    assign rx_if.FERR  = ferr_q;
    assign rx_if.BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at D=16, H=8: directed frame table,
// hand-written corner sequences, and randomized frames against a frame-level model.
module tb_uart_rx;

    localparam int FCLK  = 1600;
    localparam int BAUDS = 100;
    localparam int D     = FCLK / BAUDS;
    localparam int H     = D / 2;
    // RXD fall to pulse: 2 synchronizer cycles, then t0+H+9*D+1.
    localparam int PULSE_LAT = 2 + H + 9 * D + 1;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_after;
        int         gap_after;
        bit         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    typedef struct {
        bit         ferr;
        logic [7:0] dout;
        int         cyc;
    } exp_t;

    logic CLK  = 1'b0;
    logic RST_ = 1'b0;
    uart_rx_if bus ();

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   prev_pulse = 1'b0;
    logic [7:0] model_dout;
    vec_t vecs[5];

    uart_rx #(.Bauds(BAUDS), .Fclk(FCLK)) dut (
        .CLK   (CLK),
        .RST_  (RST_),
        .rx_if (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Every VALID/FERR pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (bus.VALID || bus.FERR) begin
            check("pulse_exclusive", {31'd0, bus.VALID && bus.FERR}, 32'd0);
            check("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: VALID=%0b FERR=%0b at cycle %0d, required none",
                         bus.VALID, bus.FERR, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_is_ferr", {31'd0, bus.FERR}, {31'd0, e.ferr});
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_dout", {24'd0, bus.DOUT}, {24'd0, e.dout});
                if (bus.VALID) check("busy_at_valid", {31'd0, bus.BUSY}, 32'd0);
            end
        end
        prev_pulse = bus.VALID || bus.FERR;
    end

    // Drives one 8N1 frame starting at the current negedge; optionally
    // disturbs data bits away from their mid-bit sample point.
    task automatic send_frame(input logic [7:0] data, input logic stop, input bit noise,
                              input bit exp_ferr, input logic [7:0] exp_dout);
        exp_t e;
        logic b;
        e.ferr = exp_ferr;
        e.dout = exp_dout;
        e.cyc  = cyc + PULSE_LAT;
        exp_q.push_back(e);
        bus.RXD = 1'b0;
        repeat (D) @(negedge CLK);
        for (int i = 0; i < 9; i++) begin
            b = (i < 8) ? data[i] : stop;
            for (int c = 0; c < D; c++) begin
                bus.RXD = (noise && i < 8 && c >= 1 && c <= 3) ? ~b : b;
                @(negedge CLK);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dout"},  {24'd0, bus.DOUT},  32'd0);
        check({tag, "_valid"}, {31'd0, bus.VALID}, 32'd0);
        check({tag, "_ferr"},  {31'd0, bus.FERR},  32'd0);
        check({tag, "_busy"},  {31'd0, bus.BUSY},  32'd0);
    endtask

    initial begin
        int busy_cnt;
        logic [7:0] d;
        logic       stop;
        bit         noise;
        int         low;
        int         gap;
        logic [7:0] pre81;

        bus.RXD    = 1'b1;
        RST_       = 1'b0;
        model_dout = 8'h00;

        //            data   stop  low gap ferr  dout
        vecs[0] = '{8'h55, 1'b1, 0,  20, 1'b0, 8'h55};
        vecs[1] = '{8'h00, 1'b1, 0,  0,  1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0,  20, 1'b0, 8'hFF};
        vecs[3] = '{8'hA5, 1'b0, 40, 20, 1'b1, 8'hFF};
        vecs[4] = '{8'h3C, 1'b1, 0,  20, 1'b0, 8'h3C};

        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RST_ = 1'b1;
        repeat (5) @(negedge CLK);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, vecs[i].exp_ferr, vecs[i].exp_dout);
            if (vecs[i].low_after > 0) begin
                bus.RXD = 1'b0;
                repeat (vecs[i].low_after) @(negedge CLK);
            end
            if (vecs[i].exp_ferr) check("ferr_dout_held", {24'd0, bus.DOUT}, {24'd0, vecs[i].exp_dout});
            bus.RXD = 1'b1;
            repeat (vecs[i].gap_after) @(negedge CLK);
        end
        model_dout = 8'h3C;

        // Start-bit glitch: 4 low cycles, rejected at the mid-start sample.
        bus.RXD = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 4) bus.RXD = 1'b1;
            @(negedge CLK);
            if (bus.BUSY) busy_cnt++;
        end
        check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        check("glitch_busy_max", {31'd0, busy_cnt <= 9}, 32'd1);
        check("glitch_busy_end", {31'd0, bus.BUSY}, 32'd0);
        check("glitch_dout_held", {24'd0, bus.DOUT}, {24'd0, model_dout});

        // Reset during bit 3 of 0x81: frame abandoned, outputs cleared.
        pre81 = 8'h81;
        bus.RXD = 1'b0;
        repeat (D) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            bus.RXD = pre81[i];
            repeat (D) @(negedge CLK);
        end
        bus.RXD = pre81[3];
        repeat (H) @(negedge CLK);
        check("busy_mid_frame", {31'd0, bus.BUSY}, 32'd1);
        RST_    = 1'b0;
        bus.RXD = 1'b1;
        repeat (2) @(negedge CLK);
        check_idle_outputs("midreset");
        RST_       = 1'b1;
        model_dout = 8'h00;
        repeat (10) @(negedge CLK);
        check_idle_outputs("post_reset");
        send_frame(8'h42, 1'b1, 1'b0, 1'b0, 8'h42);
        model_dout = 8'h42;
        bus.RXD = 1'b1;
        repeat (20) @(negedge CLK);

        // Random frames: a good stop bit delivers the byte, a low one flags an
        // error and leaves the last good byte in place.
        for (int n = 0; n < 30; n++) begin
            d     = 8'($urandom);
            stop  = ($urandom_range(3) != 0);
            noise = 1'($urandom_range(1));
            low   = stop ? 0 : int'($urandom_range(30));
            gap   = stop ? int'($urandom_range(10)) : 2 + int'($urandom_range(10));
            if (stop) begin
                send_frame(d, stop, noise, 1'b0, d);
                model_dout = d;
            end else begin
                send_frame(d, stop, noise, 1'b1, model_dout);
            end
            if (low > 0) begin
                bus.RXD = 1'b0;
                repeat (low) @(negedge CLK);
            end
            bus.RXD = 1'b1;
            repeat (gap) @(negedge CLK);
        end

        repeat (200) @(negedge CLK);
        check("pending_pulses", exp_q.size(), 32'd0);
        check("final_dout", {24'd0, bus.DOUT}, {24'd0, model_dout});
        check("final_busy", {31'd0, bus.BUSY}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (100000) @(posedge CLK);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter Bauds, default 300, serial bit rate in bits/s.
REQ-002 Parameter Fclk, default 48_000_000, CLK frequency in Hz.
REQ-003 CLK  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 RST_  input  1  reset, synchronous and active-low.
REQ-005 RXD  input  1  asynchronous serial line, idle high, 8N1 format, LSB first.
REQ-006 DOUT  output  8  last correctly received byte; held until the next good frame.
REQ-007 VALID  output  1  one-cycle pulse; DOUT holds a newly received byte.
REQ-008 FERR  output  1  one-cycle pulse; frame error (stop bit sampled low).
REQ-009 BUSY  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-010 D = Fclk/Bauds (integer division) clocks per bit; H = D/2; the block SHALL reject at elaboration any configuration with D < 4.
REQ-011 RXD SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs, which lags RXD by 2 cycles.
REQ-012 States: IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: on the first cycle t0 with rxs=0, go to START and load the bit counter; BUSY=1 from t0+1.
REQ-014 START: at t0+H, sample rxs; if 1 (glitch), return to IDLE with no pulse; if 0, go to DATA.
REQ-015 DATA: bit i (i=0..7) is sampled at t0+H+(i+1)*D and shifted in LSB first; after bit 7, go to STOP.
REQ-016 STOP: sample at t0+H+9*D; if 1, DOUT<=shift register and VALID=1 on cycle t0+H+9*D+1, then IDLE.
REQ-017 Good-frame re-arm: after a good frame, IDLE is re-entered so that a new start bit is detectable from cycle t0+H+9*D+1 onward, including back-to-back frames with no idle gap.
REQ-018 STOP with rxs=0: FERR=1 on cycle t0+H+9*D+1; DOUT unchanged; go to BREAK.
REQ-019 BREAK: wait until rxs=1, then IDLE; no start detection while in BREAK.
REQ-020 VALID and FERR SHALL be mutually exclusive and never asserted for more than one consecutive cycle.
REQ-021 Bit counter width: $clog2(D)+1 bits; bit index: 3 bits, with no wrap beyond 7.
REQ-022 RXD transitions between sample points SHALL NOT affect received data (single mid-bit sample, no majority vote).

Reset
REQ-023 While RST_=0 at a CLK edge, the next state SHALL be: state=IDLE, DOUT=0, VALID=0, FERR=0, BUSY=0, synchronizer flops=1, counters=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no VALID/FERR pulse; after release, a frame is received only from the next falling edge.

Structure
REQ-025 A shared package SHALL hold the state encoding constants and the D/H divisor computation, for reuse by the transmit side.
REQ-026 The synchronizer SHALL be a separate sub-module, sync2 (2 flops, reset value 1); there are no other sub-modules.

Verification (Fclk=1600, Bauds=100, so D=16, H=8)
REQ-027 Good frame: send 0x55 8N1 -> VALID pulses once, DOUT=0x55, FERR never set, BUSY low after VALID.
REQ-028 Back-to-back frames: 0x00 then 0xFF, no gap -> two VALID pulses 160 cycles apart, DOUT=0x00 then DOUT=0xFF.
REQ-029 Glitch: RXD low for 4 cycles from idle -> return to IDLE, no VALID/FERR, BUSY high for at most 9 cycles.
REQ-030 Framing error: 0xA5 with stop bit low, line low for 40 more cycles, then 0x3C -> FERR pulses once, DOUT stays at its prior value, then VALID with DOUT=0x3C.
REQ-031 Mid-frame reset: RST_=0 for 2 cycles during bit 3 of 0x81, followed by a clean 0x42 -> no pulse for the aborted frame, all outputs 0 after reset, then VALID with DOUT=0x42.
REQ-032 Timing: exact-cycle check that VALID is high on the cycle t0+H+9*D+1 = t0+153 relative to rxs falling.
